fp_add_issuer: RTL and testbench
================================

Name: fp_add_issuer

Overview:
Initiator side of the stb/ack floating-point operator protocol. It accepts an operand pair from a valid/ready requester and drives a 32-bit single-precision stb/ack operator core (for example the FP adder):
- sends operand A, then operand B;
- collects result Z;
- returns Z to the requester.

A watchdog aborts hung transactions. The block sits between the bus-side register block and the FP operator core.

Parameters:
TIMEOUT_CYCLES, 256, cycles allowed from operation start to Z handshake before abort (min 4)
CNT_W, 16, width of the watchdog counter and optional latency counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  1  requester has an operand pair
req_ready  out  1  issuer can accept a pair
req_a  in  32  operand A (IEEE-754 single)
req_b  in  32  operand B
resp_valid  out  1  result available
resp_ready  in  1  requester accepts result
resp_z  out  32  result word
resp_timeout  out  1  result is a watchdog abort, not a core result
core_a  out  32  to core input_a
core_a_stb  out  1  to core input_a_stb
core_a_ack  in  1  from core input_a_ack
core_b  out  32  to core input_b
core_b_stb  out  1  to core input_b_stb
core_b_ack  in  1  from core input_b_ack
core_z  in  32  from core output_z
core_z_stb  in  1  from core output_z_stb
core_z_ack  out  1  to core output_z_ack

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE; all stb/ack outputs 0.
  - req_ready=0 while in reset, 1 in IDLE after release.
  - resp_valid=0, resp_z=0, resp_timeout=0, core_a=0, core_b=0, watchdog=0.
- All outputs are registered except req_ready, which is (state==IDLE).
- Transfer rule on every channel: a word moves on a rising edge where stb and ack are both 1.
- The core treats core_a_stb=0 as a synchronous abort. core_a_stb therefore stays 1 continuously from SEND_A entry until the Z transfer or timeout.
- State machine:
  - IDLE: core_a_stb=0.
    - On req_valid&req_ready: latch req_a→core_a and req_b→core_b; core_a_stb<=1; watchdog<=0; go SEND_A.
    - IDLE lasts ≥1 cycle, guaranteeing a stb-low gap between ops.
  - SEND_A: on core_a_stb&core_a_ack, core_b_stb<=1 and go SEND_B.
  - SEND_B: on core_b_stb&core_b_ack, core_b_stb<=0 and go WAIT_Z.
  - WAIT_Z:
    - core_z_ack<=1 on entry.
    - On core_z_stb&core_z_ack: resp_z<=core_z, resp_timeout<=0, core_z_ack<=0, core_a_stb<=0, resp_valid<=1; go RESP.
  - RESP: hold resp_valid, resp_z and resp_timeout. On resp_valid&resp_ready: resp_valid<=0; go IDLE.
- Watchdog:
  - Increments every cycle in SEND_A, SEND_B and WAIT_Z.
  - When it equals TIMEOUT_CYCLES-1 without a completing handshake that edge:
    - drop core_a_stb, core_b_stb and core_z_ack;
    - resp_z<=32'h7FC00000, resp_timeout<=1, resp_valid<=1; go RESP.
  - A handshake and the timeout on the same edge: the handshake wins.
- Acks arriving in states that do not expect them are ignored. core_a_ack and core_b_ack may both be high; only the current state's channel transfers.
- core_a and core_b stay stable from latch until the next IDLE accept.
- Throughput: one op in flight. Minimum issuer overhead is 1 IDLE cycle plus 1 RESP cycle.

Optional Feature:
FP_ISSUE_PERF_EN
- Defined:
  - Adds output lat_cycles [CNT_W-1:0], reset 0.
  - On each Z transfer it loads the watchdog value+1, i.e. the cycle count from SEND_A entry to the Z handshake edge inclusive.
  - Not updated on timeout.
  - Adds output op_count [CNT_W-1:0], incremented on each RESP→IDLE, wrapping at 2^CNT_W.
- Undefined: neither port exists and no counter logic is present.

Test Plan:
- With the FP adder core attached: req 3F800000+40000000 → resp_z=40400000, resp_timeout=0. Confirm core_a_stb stays high through the Z handshake and drops to 0 for ≥1 cycle before the next op.
- Hold resp_ready=0 for 10 cycles after resp_valid with 3F800000+BF800000 → resp_valid and resp_z=00000000 held stable, req_ready=0 throughout; transfer on the first resp_ready=1 edge.
- Stub core that never asserts core_z_stb, TIMEOUT_CYCLES=16 → resp_valid rises at cycle 16 after accept with resp_z=7FC00000, resp_timeout=1, all core stb/ack=0; the next op completes normally.
- Three back-to-back requests with req_valid held high → three responses in order, each preceded by an IDLE cycle with core_a_stb=0.
- Assert rst=0 during WAIT_Z → outputs clear asynchronously before the next clk edge; after release, req_ready=1 and a new op completes correctly.
- Stub core asserting core_z_stb on the exact edge the watchdog expires → the core result is returned, resp_timeout=0.

Source files
------------

// File: rtl/fp_add_issuer.sv
// fp_add_issuer: initiator for a stb/ack floating-point operator core.
// Takes an operand pair from a valid/ready requester, sends A then B to the
// core, collects Z and hands it back. A watchdog turns a hung operation into
// a quiet-NaN response flagged with resp_timeout.
// Optional build macro FP_ISSUE_PERF_EN adds lat_cycles and op_count outputs.
module fp_add_issuer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_z,
  output logic             resp_timeout,
  output logic [31:0]      core_a,
  output logic             core_a_stb,
  input  logic             core_a_ack,
  output logic [31:0]      core_b,
  output logic             core_b_stb,
  input  logic             core_b_ack,
  input  logic [31:0]      core_z,
  input  logic             core_z_stb,
  output logic             core_z_ack
`ifdef FP_ISSUE_PERF_EN
  ,
  output logic [CNT_W-1:0] lat_cycles,
  output logic [CNT_W-1:0] op_count
`endif
);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  state_t            state_q;
  logic [CNT_W-1:0]  wd_q;
  logic [CNT_W-1:0]  wd_d;
  logic [31:0]       core_a_q, core_b_q, resp_z_q;
  logic              a_stb_q, b_stb_q, z_ack_q;
  logic              resp_valid_q, resp_timeout_q;
  logic              hs_a, hs_b, hs_z;
`ifdef FP_ISSUE_PERF_EN
  logic [CNT_W-1:0]  lat_q, opc_q;
`endif

  // Only the channel owned by the current state may transfer; stray acks elsewhere are ignored.
  always_comb begin
    hs_a = (state_q == SEND_A) && a_stb_q && core_a_ack;
    hs_b = (state_q == SEND_B) && b_stb_q && core_b_ack;
    hs_z = (state_q == WAIT_Z) && core_z_stb && z_ack_q;
    wd_d = wd_q + 1'b1;
  end

  // Operation sequencer with watchdog; every output except req_ready is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      wd_q           <= '0;
      core_a_q       <= '0;
      core_b_q       <= '0;
      resp_z_q       <= '0;
      a_stb_q        <= 1'b0;
      b_stb_q        <= 1'b0;
      z_ack_q        <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
`ifdef FP_ISSUE_PERF_EN
      lat_q          <= '0;
      opc_q          <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // core_a_stb is low here, which gives the core its abort gap between ops.
          if (req_valid) begin
            core_a_q <= req_a;
            core_b_q <= req_b;
            a_stb_q  <= 1'b1;
            wd_q     <= '0;
            state_q  <= SEND_A;
          end
        end
        SEND_A, SEND_B, WAIT_Z: begin
          wd_q <= wd_d;
          if (hs_a) begin
            b_stb_q <= 1'b1;
            state_q <= SEND_B;
          end else if (hs_b) begin
            b_stb_q <= 1'b0;
            z_ack_q <= 1'b1;
            state_q <= WAIT_Z;
          end else if (hs_z) begin
            // A Z handshake on the expiry edge still wins over the watchdog.
            resp_z_q       <= core_z;
            resp_timeout_q <= 1'b0;
            resp_valid_q   <= 1'b1;
            z_ack_q        <= 1'b0;
            a_stb_q        <= 1'b0;
            state_q        <= RESP;
`ifdef FP_ISSUE_PERF_EN
            lat_q          <= wd_d;
`endif
          end else if (wd_q >= WD_LAST) begin
            // >= rather than == so an A/B handshake on the expiry edge cannot dodge the watchdog.
            a_stb_q        <= 1'b0;
            b_stb_q        <= 1'b0;
            z_ack_q        <= 1'b0;
            resp_z_q       <= QNAN;
            resp_timeout_q <= 1'b1;
            resp_valid_q   <= 1'b1;
            state_q        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
`ifdef FP_ISSUE_PERF_EN
            opc_q        <= opc_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // req_ready must read 0 while reset is held, even though the state is already IDLE.
  assign req_ready    = rst && (state_q == IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_z       = resp_z_q;
  assign resp_timeout = resp_timeout_q;
  assign core_a       = core_a_q;
  assign core_a_stb   = a_stb_q;
  assign core_b       = core_b_q;
  assign core_b_stb   = b_stb_q;
  assign core_z_ack   = z_ack_q;
`ifdef FP_ISSUE_PERF_EN
  assign lat_cycles   = lat_q;
  assign op_count     = opc_q;
`endif

endmodule

// File: tb/tb_fp_add_issuer.sv
// Directed bench for fp_add_issuer with a small stb/ack core model whose
// results come from a table of hand-computed single-precision sums.
module tb_fp_add_issuer;

  localparam int CNT_W = 16;

  logic             clk, rst;
  logic             req_valid, req_ready;
  logic [31:0]      req_a, req_b;
  logic             resp_valid, resp_ready, resp_timeout;
  logic [31:0]      resp_z;
  logic [31:0]      core_a, core_b, core_z;
  logic             core_a_stb, core_a_ack, core_b_stb, core_b_ack;
  logic             core_z_stb, core_z_ack;
`ifdef FP_ISSUE_PERF_EN
  logic [CNT_W-1:0] lat_cycles, op_count;
`endif

  int checks = 0;
  int errors = 0;

  fp_add_issuer #(.TIMEOUT_CYCLES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z),
    .resp_timeout(resp_timeout),
    .core_a(core_a), .core_a_stb(core_a_stb), .core_a_ack(core_a_ack),
    .core_b(core_b), .core_b_stb(core_b_stb), .core_b_ack(core_b_ack),
    .core_z(core_z), .core_z_stb(core_z_stb), .core_z_ack(core_z_ack)
`ifdef FP_ISSUE_PERF_EN
    , .lat_cycles(lat_cycles), .op_count(op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed IEEE-754 single sums for the pairs used below.
  function automatic logic [31:0] fadd_tbl(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1 + 2 = 3
      {32'h3F800000, 32'hBF800000}: return 32'h00000000; // 1 + -1 = +0
      {32'h40000000, 32'h40400000}: return 32'h40A00000; // 2 + 3 = 5
      {32'h40000000, 32'h40000000}: return 32'h40800000; // 2 + 2 = 4
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // Core model: acks held high, Z offered after B arrives, gated by z_en, dropped on abort.
  logic [31:0] cap_a = '0, cap_b = '0;
  logic        z_armed = 1'b0;
  logic        z_en;
  assign core_z_stb = z_en & z_armed;
  assign core_z     = fadd_tbl(cap_a, cap_b);
  always @(posedge clk) begin
    if (core_a_stb && core_a_ack) cap_a <= core_a;
    if (core_b_stb && core_b_ack) cap_b <= core_b;
    if (!core_a_stb)                    z_armed <= 1'b0;
    else if (core_b_stb && core_b_ack)  z_armed <= 1'b1;
    else if (core_z_stb && core_z_ack)  z_armed <= 1'b0;
  end

  // Requester-side monitor: response order and the stb-low gap at every accept.
  logic [31:0] resp_q[$];
  int n_acc = 0, gap_bad = 0;
  always @(posedge clk) begin
    if (resp_valid && resp_ready) resp_q.push_back(resp_z);
    if (req_valid && req_ready) begin
      n_acc <= n_acc + 1;
      if (core_a_stb !== 1'b0) gap_bad <= gap_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 100; i++) begin
      if (req_ready) break;
      step();
    end
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (resp_valid) break;
      step();
    end
    check({tag, "_resp_seen"}, {31'd0, resp_valid}, 32'd1);
  endtask

  logic [31:0] bb_a[3] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
  logic [31:0] bb_b[3] = '{32'h40000000, 32'hBF800000, 32'h40400000};
  logic [31:0] bb_z[3] = '{32'h40400000, 32'h00000000, 32'h40A00000};

  initial begin
    int base, acc0;
    rst = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    core_a_ack = 1'b1; core_b_ack = 1'b1; z_en = 1'b1;

    // Reset state
    repeat (2) step();
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_z", resp_z, 32'd0);
    check("rst_stbs", {29'd0, core_a_stb, core_b_stb, core_z_ack}, 32'd0);
    check("rst_core_a", core_a, 32'd0);
    rst = 1'b1;
    step();
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // 1 + 2 with the cycle-by-cycle handshake sequence
    issue("t1", 32'h3F800000, 32'h40000000);
    check("t1_a_stb_sendA", {31'd0, core_a_stb}, 32'd1);
    check("t1_core_a", core_a, 32'h3F800000);
    check("t1_core_b", core_b, 32'h40000000);
    step();
    check("t1_b_stb", {30'd0, core_a_stb, core_b_stb}, 32'd3);
    step();
    check("t1_waitz", {29'd0, core_a_stb, core_b_stb, core_z_ack}, 32'b101);
    step();
    check("t1_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("t1_resp_z", resp_z, 32'h40400000);
    check("t1_timeout", {31'd0, resp_timeout}, 32'd0);
    check("t1_stbs_after_z", {29'd0, core_a_stb, core_b_stb, core_z_ack}, 32'd0);
`ifdef FP_ISSUE_PERF_EN
    check("t1_lat", {16'd0, lat_cycles}, 32'd3);
`endif
    step();
    check("t1_idle", {30'd0, req_ready, core_a_stb}, 32'b10);
    check("t1_resp_done", {31'd0, resp_valid}, 32'd0);
`ifdef FP_ISSUE_PERF_EN
    check("t1_opcount", {16'd0, op_count}, 32'd1);
`endif

    // Back-pressure on the response: 1 + -1 held for 10 cycles
    resp_ready = 1'b0;
    issue("t2", 32'h3F800000, 32'hBF800000);
    wait_resp("t2");
    for (int i = 0; i < 10; i++) begin
      check("t2_hold", {29'd0, resp_valid, resp_timeout, req_ready}, 32'b100);
      check("t2_hold_z", resp_z, 32'h00000000);
      step();
    end
    resp_ready = 1'b1;
    step();
    check("t2_released", {30'd0, resp_valid, req_ready}, 32'b01);

    // Core never answers: abort on edge 16 after accept, then a normal op
    z_en = 1'b0;
    issue("t3", 32'h3F800000, 32'h40000000);
    repeat (15) step();
    check("t3_not_early", {31'd0, resp_valid}, 32'd0);
    step();
    check("t3_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("t3_resp_z", resp_z, 32'h7FC00000);
    check("t3_timeout", {31'd0, resp_timeout}, 32'd1);
    check("t3_stbs", {29'd0, core_a_stb, core_b_stb, core_z_ack}, 32'd0);
    z_en = 1'b1;
    step();
    issue("t3b", 32'h40000000, 32'h40400000);
    wait_resp("t3b");
    check("t3b_resp_z", resp_z, 32'h40A00000);
    check("t3b_timeout", {31'd0, resp_timeout}, 32'd0);
    step();

    // Three back-to-back requests with req_valid held high
    base = resp_q.size();
    acc0 = n_acc;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_a = bb_a[k];
      req_b = bb_b[k];
      for (int i = 0; i < 100; i++) begin
        if (req_ready) break;
        step();
      end
      check("t4_ready", {31'd0, req_ready}, 32'd1);
      step();
    end
    req_valid = 1'b0;
    wait_resp("t4");
    step();
    check("t4_count", resp_q.size() - base, 32'd3);
    check("t4_accepts", n_acc - acc0, 32'd3);
    check("t4_gap", gap_bad, 32'd0);
    for (int k = 0; k < 3; k++)
      if (resp_q.size() > base + k) check("t4_resp", resp_q[base + k], bb_z[k]);

    // Asynchronous reset in the middle of WAIT_Z
    z_en = 1'b0;
    issue("t5", 32'h40000000, 32'h40000000);
    repeat (2) step();
    check("t5_in_waitz", {31'd0, core_z_ack}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_async_stbs", {29'd0, core_a_stb, core_b_stb, core_z_ack}, 32'd0);
    check("t5_async_ctl", {30'd0, req_ready, resp_valid}, 32'd0);
    check("t5_async_core_a", core_a, 32'd0);
    check("t5_async_core_b", core_b, 32'd0);
    #2 rst = 1'b1;
    step();
    check("t5_ready_after", {31'd0, req_ready}, 32'd1);
    z_en = 1'b1;
    issue("t5b", 32'h40000000, 32'h40000000);
    wait_resp("t5b");
    check("t5b_resp_z", resp_z, 32'h40800000);
    step();

    // Z handshake lands on the exact watchdog expiry edge
    z_en = 1'b0;
    issue("t6", 32'h3F800000, 32'h40000000);
    repeat (15) step();
    check("t6_not_early", {31'd0, resp_valid}, 32'd0);
    z_en = 1'b1;
    step();
    check("t6_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("t6_resp_z", resp_z, 32'h40400000);
    check("t6_timeout", {31'd0, resp_timeout}, 32'd0);
`ifdef FP_ISSUE_PERF_EN
    check("t6_lat", {16'd0, lat_cycles}, 32'd16);
`endif
    step();
`ifdef FP_ISSUE_PERF_EN
    check("t6_opcount", {16'd0, op_count}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
